// File: rtl/cordic_share_arb.sv
// Shares one iterative CORDIC sine/cosine engine between two requesters, with a WAIT watchdog.
// Optional macro REQ0_PRIORITY_EN: requester 0 wins every tie instead of round-robin.
module cordic_share_arb #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_angle,
  output logic             req0_ready,
  output logic             rsp0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_angle,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_sin,
  output logic [WIDTH-1:0] rsp_cos,
  output logic             rsp_err,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_angle,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_sin,
  input  logic [WIDTH-1:0] eng_cos,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               run_q, run_d;
  logic               last_grant_q, last_grant_d;
  logic               gnt_q, gnt_d;
  logic [WIDTH-1:0]   eng_angle_q, eng_angle_d;
  logic [WIDTH-1:0]   rsp_sin_q, rsp_sin_d;
  logic [WIDTH-1:0]   rsp_cos_q, rsp_cos_d;
  logic               rsp_err_q, rsp_err_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               grant_s;
  logic               grant_sel_s;

  // Arbitration: run_q keeps ready low on the first cycle out of reset.
  always_comb begin
    run_d   = 1'b1;
    grant_s = run_q && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
`ifdef REQ0_PRIORITY_EN
      grant_sel_s = 1'b0;
`else
      grant_sel_s = ~last_grant_q;
`endif
    end else if (req1_valid) begin
      grant_sel_s = 1'b1;
    end else begin
      grant_sel_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done pulse beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done || (timer_q == TMR_LAST)) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: grant capture, watchdog and result latching.
  always_comb begin
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    eng_angle_d  = eng_angle_q;
    rsp_sin_d    = rsp_sin_q;
    rsp_cos_d    = rsp_cos_q;
    rsp_err_d    = rsp_err_q;
    timer_d      = timer_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          last_grant_d = grant_sel_s;
          gnt_d        = grant_sel_s;
          eng_angle_d  = grant_sel_s ? req1_angle : req0_angle;
        end else begin
          gnt_d = gnt_q;
        end
      end
      S_ISSUE: timer_d = {TMR_W{1'b0}};
      S_WAIT: begin
        if (eng_done) begin
          rsp_sin_d = eng_sin;
          rsp_cos_d = eng_cos;
          rsp_err_d = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          rsp_sin_d = {WIDTH{1'b0}};
          rsp_cos_d = {WIDTH{1'b0}};
          rsp_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESP:  timer_d = timer_q;
      default: timer_d = timer_q;
    endcase
  end

  // Datapath registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_q        <= 1'b0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      eng_angle_q  <= {WIDTH{1'b0}};
      rsp_sin_q    <= {WIDTH{1'b0}};
      rsp_cos_q    <= {WIDTH{1'b0}};
      rsp_err_q    <= 1'b0;
      timer_q      <= {TMR_W{1'b0}};
    end else begin
      run_q        <= run_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      eng_angle_q  <= eng_angle_d;
      rsp_sin_q    <= rsp_sin_d;
      rsp_cos_q    <= rsp_cos_d;
      rsp_err_q    <= rsp_err_d;
      timer_q      <= timer_d;
    end
  end

  // Handshake outputs decoded from state; ready is the only combinational-input path.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    eng_start  = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        req0_ready = grant_s && !grant_sel_s;
        req1_ready = grant_s && grant_sel_s;
      end
      S_ISSUE: eng_start = 1'b1;
      S_WAIT:  busy = 1'b1;
      S_RESP: begin
        rsp0_valid = !gnt_q;
        rsp1_valid = gnt_q;
      end
      default: busy = 1'b0;
    endcase
  end

  assign eng_angle = eng_angle_q;
  assign rsp_sin   = rsp_sin_q;
  assign rsp_cos   = rsp_cos_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cordic_share_arb.sv
// Scoreboard bench for cordic_share_arb: random requesters and a behavioural engine
// model push expectations; a negedge monitor pops and compares on every response.
module tb_cordic_share_arb;
  localparam int W  = 12;
  localparam int TO = 64;

  logic         clock = 1'b0;
  logic         resetn;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_angle, req1_angle;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_sin, rsp_cos, eng_angle;
  logic         rsp_err, eng_start, busy;
  logic         eng_done = 1'b0;
  logic [W-1:0] eng_sin = '0, eng_cos = '0;

  cordic_share_arb dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_angle(req0_angle), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_angle(req1_angle), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_angle(eng_angle), .eng_done(eng_done),
    .eng_sin(eng_sin), .eng_cos(eng_cos), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  typedef struct {int who; logic [W-1:0] ang; int acc;} pend_t;
  typedef struct {int who; logic [W-1:0] s; logic [W-1:0] c; logic e; int due;} exp_t;

  pend_t        pend_q[$];
  exp_t         exp_q[$];
  int           glog[$];
  int           outst = 0, last_rsp = -10, rel_cyc = 0;
  logic         m_last = 1'b1;
  logic [W-1:0] h_sin = '0, h_cos = '0;
  logic         h_err = 1'b0;

  // Engine model controls
  int           done_cyc = -100;
  logic         inj_done = 1'b0;
  logic [W-1:0] e_sin = '0, e_cos = '0;
  int           lat_mode = 0, fix_lat = 12;
  logic         fix_data_en = 1'b0;
  logic [W-1:0] fix_data = '0;

  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef REQ0_PRIORITY_EN
      return 0;
`else
      return (last == 1'b1) ? 0 : 1;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  // Engine driver: pulse done on the scheduled cycle, junk data otherwise.
  always @(posedge clock) begin
    #1;
    if (inj_done || cyc == done_cyc) begin
      eng_done = 1'b1; eng_sin = e_sin; eng_cos = e_cos;
    end else begin
      eng_done = 1'b0; eng_sin = W'($urandom); eng_cos = W'($urandom);
    end
  end

  int    m_w, m_l, m_r;
  pend_t m_p;
  exp_t  m_e;

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (!resetn) begin
      pend_q.delete(); exp_q.delete();
      outst = 0; m_last = 1'b1; h_sin = '0; h_cos = '0; h_err = 1'b0; done_cyc = -100;
    end else begin
      chk("busy", busy, outst != 0);
      if (rsp0_valid || rsp1_valid) begin
        chk("dual_rsp", rsp0_valid && rsp1_valid, 0);
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          m_e = exp_q.pop_front();
          chk("rsp_who", rsp1_valid, m_e.who);
          chk("rsp_cycle", cyc, m_e.due);
          chk("rsp_sin", rsp_sin, m_e.s);
          chk("rsp_cos", rsp_cos, m_e.c);
          chk("rsp_err", rsp_err, m_e.e);
          h_sin = m_e.s; h_cos = m_e.c; h_err = m_e.e;
        end
        outst = 0; last_rsp = cyc;
      end else begin
        chk("hold_sin", rsp_sin, h_sin);
        chk("hold_cos", rsp_cos, h_cos);
        chk("hold_err", rsp_err, h_err);
      end
      if (req0_ready || req1_ready) begin
        m_w = req1_ready ? 1 : 0;
        chk("dual_ready", req0_ready && req1_ready, 0);
        chk("grant", m_w, pick(req0_valid, req1_valid, m_last));
        chk("ready_wo_valid", (m_w == 1) ? req1_valid : req0_valid, 1);
        chk("overlap", outst, 0);
        m_p.who = m_w; m_p.ang = (m_w == 1) ? req1_angle : req0_angle; m_p.acc = cyc;
        pend_q.push_back(m_p);
        glog.push_back(m_w);
        m_last = m_w[0]; outst = 1;
      end else if (outst == 0 && cyc > last_rsp && cyc > rel_cyc + 1 && (req0_valid || req1_valid)) begin
        chk("no_grant", 0, 1);
      end
      if (eng_start) begin
        if (pend_q.size() == 0) chk("stray_start", 1, 0);
        else begin
          m_p = pend_q.pop_front();
          chk("start_cycle", cyc, m_p.acc + 1);
          chk("eng_angle", eng_angle, m_p.ang);
          if (lat_mode == 0) m_l = fix_lat;
          else if (lat_mode == 1) m_l = $urandom_range(10, 1);
          else begin
            m_r = $urandom % 10;
            m_l = (m_r == 0) ? 200 : (m_r == 1) ? TO : $urandom_range(30, 1);
          end
          e_sin = fix_data_en ? fix_data : W'($urandom);
          e_cos = fix_data_en ? fix_data : W'($urandom);
          m_e.who = m_p.who;
          if (m_l <= TO) begin
            done_cyc = cyc + m_l;
            m_e.s = e_sin; m_e.c = e_cos; m_e.e = 1'b0; m_e.due = cyc + 1 + m_l;
          end else begin
            done_cyc = cyc + TO + 3;
            m_e.s = '0; m_e.c = '0; m_e.e = 1'b1; m_e.due = cyc + 1 + TO;
          end
          exp_q.push_back(m_e);
        end
      end
      if (pend_q.size() > 0 && cyc > pend_q[0].acc + 1) begin
        chk("start_missing", 0, 1);
        m_p = pend_q.pop_front();
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("rsp_missing", 0, 1);
        m_e = exp_q.pop_front();
        outst = 0;
      end
    end
  end

  task automatic drive(input int id, input logic v, input logic [W-1:0] a);
    if (id == 0) begin req0_valid = v; req0_angle = a; end
    else begin req1_valid = v; req1_angle = a; end
  endtask

  task automatic single_req(input int id, input logic [W-1:0] ang);
    int n;
    logic got;
    n = 0; got = 1'b0;
    @(posedge clock); #1 drive(id, 1'b1, ang);
    while (!got && n < 1000) begin
      @(negedge clock);
      if ((id == 0) ? req0_ready : req1_ready) got = 1'b1;
      n++;
    end
    if (!got) chk("req_timeout", 0, 1);
    @(posedge clock); #1 drive(id, 1'b0, ang);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((outst != 0 || pend_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clock); n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    repeat (5) @(negedge clock);
  endtask

  task automatic do_req(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      int   gap, cnt;
      logic wd, got;
      gap = $urandom % 5; cnt = 0; got = 1'b0;
      wd = ($urandom % 5) == 0;
      repeat (gap + 1) @(posedge clock);
      #1 drive(id, 1'b1, W'($urandom));
      while (!got && cnt < 2000) begin
        @(negedge clock);
        if ((id == 0) ? req0_ready : req1_ready) got = 1'b1;
        else begin
          cnt++;
          if (wd) break;
          if ($urandom % 4 == 0) begin
            @(posedge clock); #1 drive(id, 1'b1, W'($urandom));
          end
        end
      end
      if (!got && !wd) chk("req_wait", 0, 1);
      @(posedge clock); #1 drive(id, 1'b0, '0);
    end
  endtask

  int g_before, n, ones;

  initial begin
    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_angle = '0; req1_angle = '0;
    repeat (3) @(negedge clock);
    chk("rst_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, eng_start, busy}, 0);
    chk("rst_data", {rsp_sin, rsp_cos}, 0);
    chk("rst_angle", eng_angle, 0);
    @(posedge clock); #2 resetn = 1'b1; rel_cyc = cyc;
    repeat (3) @(posedge clock);

    // Single request, L=12, fixed data
    lat_mode = 0; fix_lat = 12; fix_data_en = 1'b1; fix_data = 12'h5A8;
    single_req(0, 12'h200);
    wait_idle();

    // Timeout on requester 1, then a late done while idle
    fix_lat = 1000; fix_data_en = 1'b0;
    single_req(1, 12'h3C1);
    wait_idle();

    // Done coincides with the last timer value
    fix_lat = TO;
    single_req(0, 12'h0F0);
    wait_idle();

    // Withdrawn request from requester 1 while busy
    fix_lat = 20;
    g_before = glog.size();
    single_req(0, 12'h111);
    repeat (5) @(posedge clock);
    #1 drive(1, 1'b1, 12'h7FF);
    @(posedge clock); #1 drive(1, 1'b0, '0);
    wait_idle();
    chk("withdraw_grants", glog.size(), g_before + 1);

    // Reset in WAIT with an engine done pulse during reset
    fix_lat = 1000;
    single_req(0, 12'h222);
    repeat (20) @(posedge clock);
    #2 resetn = 1'b0;
    glog.delete();
    drive(0, 1'b1, 12'h0A1); drive(1, 1'b1, 12'h0B1);
    @(posedge clock); #1 inj_done = 1'b1;
    @(negedge clock);
    chk("rstw_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, eng_start, busy}, 0);
    chk("rstw_data", {rsp_sin, rsp_cos}, 0);
    chk("rstw_angle", eng_angle, 0);
    @(posedge clock); #1 inj_done = 1'b0;
    @(posedge clock); #2 resetn = 1'b1; rel_cyc = cyc;

    // Contention: both valid continuously for six accepts
    lat_mode = 1; n = 0;
    while (glog.size() < 6 && n < 1000) begin
      @(negedge clock); n++;
      if (req0_ready) begin @(posedge clock); #1 req0_angle = W'($urandom); end
      else if (req1_ready) begin @(posedge clock); #1 req1_angle = W'($urandom); end
    end
    drive(0, 1'b0, '0); drive(1, 1'b0, '0);
    if (n >= 1000) chk("contention_timeout", 0, 1);
    for (int i = 0; i < 6; i++) begin
`ifdef REQ0_PRIORITY_EN
      if (glog.size() > i) chk($sformatf("order_%0d", i), glog[i], 0);
`else
      if (glog.size() > i) chk($sformatf("order_%0d", i), glog[i], i % 2);
`endif
    end
    wait_idle();

    // Random traffic with random engine latency and occasional timeouts
    lat_mode = 2;
    fork
      do_req(0, 30);
      do_req(1, 30);
    join
    wait_idle();
    ones = 0;
    foreach (glog[i]) ones += glog[i];
    chk("random_grants_seen", (glog.size() > 12) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
